// File: rtl/spmv_axi_pkg.sv
// Shared AXI constants and helpers for the SpMV AXI read path.
//   AXI_BURST_INCR : arburst encoding for incrementing bursts
//   AXI_RESP_OKAY  : rresp encoding for a normal beat
//   CNT_W          : width of the per-requester outstanding-burst counters (cap <= 15)
//   clog2()        : ceiling log2 for elaboration-time widths
package spmv_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned CNT_W = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/spmv_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index granted most recently; search starts just after it
//   grant       : one-hot grant (zero when nothing requests)
//   grant_idx   : index of the granted requester
//   grant_valid : some requester was granted
module spmv_rr_arbiter
  import spmv_axi_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] idx;

  // Visit last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); the previous
  // winner is examined last, so it only wins again when it is alone.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spmv_axi_rd_arbiter.sv
// Shares one AXI4 read master among NUM_REQ SpMV read requesters
// (colIndex / Xi fetchers). Round-robin AR arbitration, per-requester
// outstanding-burst cap, R beats routed back by ID (arid = requester index).
//   clk, rstn                 : clock, synchronous active-low reset
//   s_arvalid/arready/araddr/arlen : per-requester AR (packed address/length)
//   s_rvalid/rready           : per-requester R handshake
//   s_rdata/rresp/rlast       : broadcast R payload
//   m_ar*                     : AXI AR channel toward memory (registered)
//   m_r*                      : AXI R channel from memory
//   outst_busy                : requester has at least one burst in flight
//   err_sticky                : bad rid, non-OKAY rresp or counter underflow seen
module spmv_axi_rd_arbiter
  import spmv_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  output logic                      m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic [3:0]                m_arqos,
  input  logic                      m_arready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [NUM_REQ-1:0]        outst_busy,
  output logic                      err_sticky
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  logic [CNT_W-1:0]   cnt      [NUM_REQ];
  logic [CNT_W-1:0]   cnt_next [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [IDX_W-1:0]   last_grant;
  logic               slot_free;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_len;
  logic               rid_ok;
  logic [IDX_W-1:0]   rid_idx;
  logic [NUM_REQ-1:0] rd_done;
  logic               underflow;
  logic               err_set;

  assign m_arsize  = 3'(clog2(DATA_W / 8));
  assign m_arburst = AXI_BURST_INCR;
  assign m_arlock  = 1'b0;
  assign m_arcache = '0;
  assign m_arprot  = '0;
  assign m_arqos   = '0;

  // ---------------- AR arbitration ----------------
  assign slot_free = !m_arvalid || m_arready;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
    end
  end

  // Gating with rstn keeps s_arready low while reset is held.
  assign arb_req = (rstn && slot_free) ? eligible : '0;

  spmv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (arb_req),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign s_arready = grant;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = s_arlen[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_arvalid  <= 1'b0;
      m_arid     <= '0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      last_grant <= '0;
    end else if (grant_valid) begin
      m_arvalid  <= 1'b1;
      m_arid     <= ID_W'(grant_idx);
      m_araddr   <= sel_addr;
      m_arlen    <= sel_len;
      last_grant <= grant_idx;
    end else if (m_arready) begin
      m_arvalid  <= 1'b0;
    end
  end

  // ---------------- R demux ----------------
  assign rid_ok  = 32'(m_rid) < NUM_REQ;
  assign rid_idx = m_rid[IDX_W-1:0];

  // Beats with an unknown ID are accepted and discarded so the bus never stalls.
  assign m_rready = rid_ok ? s_rready[rid_idx] : 1'b1;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  always_comb begin
    s_rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_rvalid[i] = m_rvalid && rid_ok && (rid_idx == IDX_W'(i));
    end
  end

  // ---------------- outstanding counters ----------------
  always_comb begin
    rd_done   = '0;
    underflow = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_next[i] = cnt[i];
      rd_done[i]  = s_rvalid[i] && m_rready && m_rlast;
      if (s_arready[i] && !rd_done[i]) begin
        cnt_next[i] = cnt[i] + 1'b1;
      end else if (!s_arready[i] && rd_done[i]) begin
        if (cnt[i] == '0) begin
          underflow = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] - 1'b1;
        end
      end
    end
  end

  assign err_set = underflow
                || (m_rvalid && !rid_ok)
                || (m_rvalid && m_rready && (m_rresp != AXI_RESP_OKAY));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
      err_sticky <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (err_set) begin
        err_sticky <= 1'b1;
      end
    end
  end

  always_comb begin
    outst_busy = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      outst_busy[i] = (cnt[i] != '0);
    end
  end

endmodule

// File: tb/tb_spmv_axi_rd_arbiter.sv
// Self-checking bench for spmv_axi_rd_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_spmv_axi_rd_arbiter;

  localparam int N    = 4;
  localparam int AW   = 48;
  localparam int DW   = 64;
  localparam int IW   = 3;
  localparam int MAXO = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [IW-1:0]   m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arlock;
  logic [3:0]      m_arcache;
  logic [2:0]      m_arprot;
  logic [3:0]      m_arqos;
  logic            m_arready;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
  logic [N-1:0]    outst_busy;
  logic            err_sticky;

  always #5 clk = ~clk;

  spmv_axi_rd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arqos(m_arqos), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .outst_busy(outst_busy), .err_sticky(err_sticky)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int          cnt [N];
  int          last_g;
  bit          mv;
  int          mid;
  logic [AW-1:0] maddr;
  logic [7:0]  mlen;
  bit          merr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    last_g = 0; mv = 0; mid = 0; maddr = '0; mlen = '0; merr = 0;
  endfunction

  // Requester that should be accepted this cycle, or -1.
  function automatic int exp_grant();
    if (!rstn) return -1;
    if (mv && !m_arready) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_g + k) % N;
      if (s_arvalid[i] && cnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_arready();
    int g;
    logic [N-1:0] v;
    g = exp_grant();
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_rready();
    int rid;
    rid = int'(m_rid);
    if (rid >= N) return 1'b1;
    return s_rready[rid];
  endfunction

  function automatic logic [N-1:0] exp_rvalid();
    logic [N-1:0] v;
    int rid;
    v = '0;
    rid = int'(m_rid);
    if (m_rvalid && rid < N) v[rid] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] exp_busy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (cnt[i] != 0);
    return v;
  endfunction

  // Advance one clock and apply the same transactions to the model.
  task automatic tick();
    int g, rid;
    bit rr, done, inc, dec;
    logic [AW-1:0] a;
    logic [7:0] l;
    g = exp_grant();
    rr = exp_rready();
    rid = int'(m_rid);
    done = m_rvalid && rr && m_rlast && (rid < N);
    a = '0; l = '0;
    if (g >= 0) begin
      a = s_araddr[g*AW +: AW];
      l = s_arlen[g*8 +: 8];
    end
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        inc = (g == i);
        dec = done && (rid == i);
        if (inc && !dec) cnt[i]++;
        else if (dec && !inc) begin
          if (cnt[i] == 0) merr = 1;
          else cnt[i]--;
        end
      end
      if (m_rvalid && rid >= N) merr = 1;
      if (m_rvalid && rr && m_rresp != 2'b00) merr = 1;
      if (g >= 0) begin
        mv = 1; mid = g; maddr = a; mlen = l; last_g = g;
      end else if (m_arready) begin
        mv = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
    m_arready = 1'b1; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    s_arvalid = '1; #1;
    n_checks++; if (s_arready !== 4'b0000) begin n_fail++; $display("FAIL reset_arready got %b exp 0000", s_arready); end
    n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", m_arvalid); end
    n_checks++; if (m_araddr !== '0 || m_arid !== '0 || m_arlen !== '0) begin n_fail++; $display("FAIL reset_arregs got addr %h id %0d len %0d exp 0", m_araddr, m_arid, m_arlen); end
    n_checks++; if (outst_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got %b exp 0000", outst_busy); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_sticky); end
    n_checks++; if (m_arsize !== 3'd3 || m_arburst !== 2'b01) begin n_fail++; $display("FAIL const_size_burst got %0d/%b exp 3/01", m_arsize, m_arburst); end
    n_checks++; if ({m_arlock, m_arcache, m_arprot, m_arqos} !== '0) begin n_fail++; $display("FAIL const_ties got %b exp 0", {m_arlock, m_arcache, m_arprot, m_arqos}); end
    s_arvalid = '0;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    do_reset();
    s_araddr[0 +: AW] = 48'h0000_4000_0000; s_arlen[7:0] = 8'd0; s_arvalid = 4'b0001; #1;
    n_checks++; if (s_arready !== 4'b0001) begin n_fail++; $display("FAIL single_arready got %b exp 0001", s_arready); end
    n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_early got %b exp 0", m_arvalid); end
    tick();
    s_arvalid = '0; #1;
    n_checks++; if (m_arvalid !== 1'b1 || m_arid !== 3'd0) begin n_fail++; $display("FAIL single_issue got v%b id%0d exp v1 id0", m_arvalid, m_arid); end
    n_checks++; if (m_araddr !== 48'h0000_4000_0000 || m_arlen !== 8'd0) begin n_fail++; $display("FAIL single_fields got %h/%0d exp 40000000/0", m_araddr, m_arlen); end
    n_checks++; if (outst_busy !== 4'b0001) begin n_fail++; $display("FAIL single_busy1 got %b exp 0001", outst_busy); end
    tick();
    n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop got %b exp 0", m_arvalid); end
    d = {$urandom, $urandom};
    m_rvalid = 1'b1; m_rid = 3'd0; m_rlast = 1'b1; m_rdata = d; m_rresp = 2'b00; s_rready = 4'b0001; #1;
    n_checks++; if (s_rvalid !== 4'b0001 || m_rready !== 1'b1) begin n_fail++; $display("FAIL single_r_route got rv%b rr%b exp 0001/1", s_rvalid, m_rready); end
    n_checks++; if (s_rdata !== d || s_rlast !== 1'b1 || s_rresp !== 2'b00) begin n_fail++; $display("FAIL single_r_data got %h/%b exp %h/1", s_rdata, s_rlast, d); end
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (outst_busy !== 4'b0000 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL single_busy0 got %b err%b exp 0000 err0", outst_busy, err_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ev;
    int prev;
    do_reset();
    for (int i = 0; i < N; i++) begin
      s_araddr[i*AW +: AW] = AW'({$urandom, $urandom});
      s_arlen[i*8 +: 8] = 8'($urandom);
    end
    s_arvalid = '1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      #1;
      ev = '0; ev[(k + 1) % N] = 1'b1;
      n_checks++; if (s_arready !== ev) begin n_fail++; $display("FAIL b2b_grant k%0d got %b exp %b", k, s_arready, ev); end
      if (prev >= 0) begin
        n_checks++; if (m_arvalid !== 1'b1 || int'(m_arid) !== prev || m_araddr !== s_araddr[prev*AW +: AW]) begin
          n_fail++; $display("FAIL b2b_issue k%0d got v%b id%0d exp v1 id%0d", k, m_arvalid, m_arid, prev);
        end
      end
      prev = (k + 1) % N;
      tick();
    end
    s_arvalid = '0;
  endtask

  task automatic test_stall();
    logic [AW-1:0] a;
    do_reset();
    a = AW'({$urandom, $urandom});
    s_araddr[1*AW +: AW] = a; s_arvalid = 4'b0010; m_arready = 1'b0; #1;
    n_checks++; if (s_arready !== 4'b0010) begin n_fail++; $display("FAIL stall_first got %b exp 0010", s_arready); end
    tick();
    s_araddr[1*AW +: AW] = ~a; s_arvalid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (s_arready !== 4'b0000) begin n_fail++; $display("FAIL stall_noaccept k%0d got %b exp 0000", k, s_arready); end
      n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== a || m_arid !== 3'd1) begin n_fail++; $display("FAIL stall_hold k%0d got v%b %h id%0d exp v1 %h id1", k, m_arvalid, m_araddr, m_arid, a); end
      tick();
    end
    m_arready = 1'b1; #1;
    n_checks++; if (s_arready !== 4'b0001) begin n_fail++; $display("FAIL stall_release got %b exp 0001", s_arready); end
    tick();
    n_checks++; if (m_arvalid !== 1'b1 || m_arid !== 3'd0) begin n_fail++; $display("FAIL stall_next got v%b id%0d exp v1 id0", m_arvalid, m_arid); end
    s_arvalid = '0;
  endtask

  task automatic test_outst_cap();
    do_reset();
    s_arvalid = 4'b0100;
    for (int k = 0; k < MAXO; k++) begin
      #1;
      n_checks++; if (s_arready !== 4'b0100) begin n_fail++; $display("FAIL cap_fill k%0d got %b exp 0100", k, s_arready); end
      tick();
    end
    #1;
    n_checks++; if (s_arready !== 4'b0000) begin n_fail++; $display("FAIL cap_block got %b exp 0000", s_arready); end
    s_arvalid = 4'b0101; #1;
    n_checks++; if (s_arready !== 4'b0001) begin n_fail++; $display("FAIL cap_other got %b exp 0001", s_arready); end
    tick();
    s_arvalid = 4'b0100;
    m_rvalid = 1'b1; m_rid = 3'd2; m_rlast = 1'b1; m_rresp = 2'b00; s_rready = 4'b0100; #1;
    n_checks++; if (s_arready !== 4'b0000 || s_rvalid !== 4'b0100 || m_rready !== 1'b1) begin
      n_fail++; $display("FAIL cap_ret got ar%b rv%b rr%b exp 0000/0100/1", s_arready, s_rvalid, m_rready);
    end
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (s_arready !== 4'b0100) begin n_fail++; $display("FAIL cap_ninth got %b exp 0100", s_arready); end
    tick();
    s_arvalid = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    s_arvalid = 4'b0010; #1;
    tick();
    m_rvalid = 1'b1; m_rid = 3'd1; m_rlast = 1'b1; m_rresp = 2'b00; s_rready = 4'b0010; #1;
    n_checks++; if (s_arready !== 4'b0010 || m_rready !== 1'b1) begin n_fail++; $display("FAIL same_both got ar%b rr%b exp 0010/1", s_arready, m_rready); end
    tick();
    s_arvalid = '0; #1;
    n_checks++; if (outst_busy !== 4'b0010) begin n_fail++; $display("FAIL same_kept got %b exp 0010", outst_busy); end
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (outst_busy !== 4'b0000 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL same_drain got %b err%b exp 0000 err0", outst_busy, err_sticky); end
    m_rvalid = 1'b1; m_rid = 3'd5; m_rlast = 1'b0; s_rready = '0; #1;
    n_checks++; if (m_rready !== 1'b1 || s_rvalid !== 4'b0000) begin n_fail++; $display("FAIL badid_route got rr%b rv%b exp 1/0000", m_rready, s_rvalid); end
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL badid_err got %b exp 1", err_sticky); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_arvalid = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rid = 3'd6; m_rlast = 1'b0;
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (m_arvalid !== 1'b1 || outst_busy !== 4'b0001 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre got v%b busy%b err%b exp 1/0001/1", m_arvalid, outst_busy, err_sticky);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1; #1;
    n_checks++; if (m_arvalid !== 1'b0 || outst_busy !== 4'b0000 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL rmid_clear got v%b busy%b err%b exp 0/0000/0", m_arvalid, outst_busy, err_sticky);
    end
    m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 3'd0; m_rlast = 1'b1; s_rready = 4'b0001; #1;
    n_checks++; if (s_rvalid !== 4'b0001) begin n_fail++; $display("FAIL rmid_route got %b exp 0001", s_rvalid); end
    tick();
    m_rvalid = 1'b0; #1;
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL rmid_underflow got %b exp 1", err_sticky); end
  endtask

  task automatic test_random();
    int id;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_arvalid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        s_araddr[i*AW +: AW] = AW'({$urandom, $urandom});
        s_arlen[i*8 +: 8] = 8'($urandom);
      end
      m_arready = ($urandom % 4) != 0;
      s_rready = N'($urandom);
      m_rvalid = $urandom % 2;
      id = $urandom % N;
      m_rid = IW'(id);
      m_rlast = (cnt[id] > 0) ? 1'($urandom) : 1'b0;
      m_rdata = {$urandom, $urandom};
      m_rresp = ($urandom % 64 == 0) ? 2'b10 : 2'b00;
      #1;
      n_checks++; if (s_arready !== exp_arready()) begin n_fail++; $display("FAIL rnd_arready c%0d got %b exp %b", cyc, s_arready, exp_arready()); end
      n_checks++; if (m_arvalid !== mv) begin n_fail++; $display("FAIL rnd_arvalid c%0d got %b exp %b", cyc, m_arvalid, mv); end
      if (mv) begin
        n_checks++; if (int'(m_arid) !== mid || m_araddr !== maddr || m_arlen !== mlen) begin
          n_fail++; $display("FAIL rnd_arfields c%0d got %0d/%h/%0d exp %0d/%h/%0d", cyc, m_arid, m_araddr, m_arlen, mid, maddr, mlen);
        end
      end
      n_checks++; if (s_rvalid !== exp_rvalid() || m_rready !== exp_rready()) begin
        n_fail++; $display("FAIL rnd_rpath c%0d got rv%b rr%b exp rv%b rr%b", cyc, s_rvalid, m_rready, exp_rvalid(), exp_rready());
      end
      n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h exp %h", cyc, s_rdata, m_rdata); end
      n_checks++; if (outst_busy !== exp_busy() || err_sticky !== merr) begin
        n_fail++; $display("FAIL rnd_status c%0d got busy%b err%b exp busy%b err%b", cyc, outst_busy, err_sticky, exp_busy(), merr);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_outst_cap();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
